// File: rtl/wb_img_packer.sv
// rtl/wb_img_packer.sv - packs 3 pixel bytes per word and writes them to a conv instance image window over Wishbone.
// Optional ack timeout guarded by WB_TIMEOUT_EN.
module wb_img_packer #(
  parameter int          NO_OF_INSTS    = 4,
  parameter int          IMG_WORDS      = 32,
  parameter logic [31:0] IMG_BASE_ADDR  = 32'h3000_0100,
  parameter int          INST_SHIFT     = 24,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [1:0]  inst_sel,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  word_cnt,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_FINISH} state_e;

  state_e             state_q;
  logic [1:0]         byte_cnt_q;
  logic [1:0]         inst_q;
  logic [15:0]        lane_q;
  logic [5:0]         word_cnt_q, word_cnt_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q;
  logic               pix_ready_q, busy_q, done_q, err_q;
  logic               cyc_q, stb_q, we_q;
  logic [3:0]         sel_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               start_ok, pix_xfer, tmo_hit;

  always_comb begin
    start_ok   = start && (32'(inst_sel) < NO_OF_INSTS);
    pix_xfer   = pix_valid && pix_ready_q;
    word_cnt_d = word_cnt_q + 6'd1;
    adr_d      = IMG_BASE_ADDR + (32'(inst_q) << INST_SHIFT) + {24'd0, word_cnt_q, 2'b00};
    tmo_hit    = TMO_EN && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      inst_q      <= 2'd0;
      lane_q      <= 16'd0;
      word_cnt_q  <= 6'd0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      tmo_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              state_q    <= S_COLLECT;
              inst_q     <= inst_sel;
              err_q      <= 1'b0;
              word_cnt_q <= 6'd0;
              byte_cnt_q <= 2'd0;
              busy_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // ready rises one cycle after entry, giving the return cycle between words
          pix_ready_q <= 1'b1;
          if (pix_xfer) begin
            case (byte_cnt_q)
              2'd0: begin
                lane_q[7:0] <= pix_data;
                byte_cnt_q  <= 2'd1;
              end
              2'd1: begin
                lane_q[15:8] <= pix_data;
                byte_cnt_q   <= 2'd2;
              end
              default: begin
                byte_cnt_q  <= 2'd0;
                pix_ready_q <= 1'b0;
                state_q     <= S_WRITE;
                cyc_q       <= 1'b1;
                stb_q       <= 1'b1;
                we_q        <= 1'b1;
                sel_q       <= 4'hf;
                adr_q       <= adr_d;
                dat_q       <= {8'd0, pix_data, lane_q};
                tmo_cnt_q   <= '0;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (wbm_ack_i) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            word_cnt_q <= word_cnt_d;
            if (word_cnt_d == 6'(IMG_WORDS)) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COLLECT;
            end
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_img_packer.sv
// tb/tb_wb_img_packer.sv - scoreboard bench for wb_img_packer (NO_OF_INSTS=3).
module tb_wb_img_packer;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  inst_sel = 2'd0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_ready, busy, done, err;
  logic [5:0]  word_cnt;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;

  always #5 clk = ~clk;

  wb_img_packer #(.NO_OF_INSTS(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .inst_sel(inst_sel),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         sb[$];
  wr_t         exp_w;
  int          checks = 0;
  int          errors = 0;
  int          ws = 0;
  bit          ack_en = 1'b1;
  int          wait_cnt = 0;
  bit          prev_stb = 1'b0;
  logic [31:0] prev_adr = 32'd0, prev_dat = 32'd0;
  int          writes = 0;
  logic [31:0] last_adr = 32'd0, last_dat = 32'd0;
  int          low_run = 0, last_low_run = 0;
  bit          xfer_q = 1'b0;

  always @(posedge clk) xfer_q <= pix_valid && pix_ready;

  // Wishbone slave with programmable wait states, plus scoreboard pop
  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      if (prev_stb) begin
        checks++;
        if (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat) begin
          errors++;
          $display("FAIL stb_stable: adr %h dat %h, required adr %h dat %h", wbm_adr_o, wbm_dat_o, prev_adr, prev_dat);
        end
      end
      if (ack_en && wait_cnt >= ws) begin
        wbm_ack_i = 1'b1;
        wait_cnt  = 0;
        writes++;
        last_adr  = wbm_adr_o;
        last_dat  = wbm_dat_o;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: adr %h dat %h, required no write", wbm_adr_o, wbm_dat_o);
        end else begin
          exp_w = sb.pop_front();
          if (wbm_adr_o !== exp_w.adr || wbm_dat_o !== exp_w.dat || wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hf) begin
            errors++;
            $display("FAIL write_word: adr %h dat %h we %b sel %h, required adr %h dat %h we 1 sel f",
                     wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, exp_w.adr, exp_w.dat);
          end
        end
      end else begin
        wbm_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      wbm_ack_i = 1'b0;
      wait_cnt  = 0;
    end
    prev_stb = wbm_cyc_o && wbm_stb_o;
    prev_adr = wbm_adr_o;
    prev_dat = wbm_dat_o;
    if (busy) begin
      if (!pix_ready) low_run++;
      else begin
        if (low_run > 0) last_low_run = low_run;
        low_run = 0;
      end
    end
  end

  task automatic do_reset();
    wb_rst_i  = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
  endtask

  task automatic run_load(input logic [1:0] inst, input int npix, input int mul, input int add,
                          input int wstates, input bit rnd, input int mid_start, input int abort_word,
                          output int done_cnt, output int cyc_to_done, output bit aborted);
    int idx = 0;
    int cycles = 0;
    int pushed = 0;
    bit fin = 1'b0;
    logic [7:0] b0, b1, b2;
    sb.delete();
    ws = wstates;
    writes = 0;
    done_cnt = 0;
    cyc_to_done = 0;
    aborted = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    inst_sel = inst;
    while (!fin) begin
      @(negedge clk); #1;
      cycles++;
      start    = (cycles == mid_start);
      inst_sel = (cycles == mid_start) ? 2'd1 : inst;
      if (xfer_q) idx++;
      if (done) begin
        done_cnt++;
        if (cyc_to_done == 0) cyc_to_done = cycles;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_with_done: busy %b, required 0", busy);
        end
      end
      if (abort_word >= 0 && wbm_stb_o && int'(word_cnt) == abort_word) begin
        aborted = 1'b1;
        fin = 1'b1;
      end
      if (idx < npix) begin
        if (idx % 3 == 0 && pushed == idx / 3) begin
          b0 = 8'(idx * mul + add);
          b1 = 8'((idx + 1) * mul + add);
          b2 = 8'((idx + 2) * mul + add);
          sb.push_back('{adr: 32'h3000_0100 + (32'(inst) << 24) + 32'(pushed * 4), dat: {8'd0, b2, b1, b0}});
          pushed++;
        end
        pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data  = 8'(idx * mul + add);
      end else begin
        pix_valid = 1'b0;
      end
      if (idx == npix && sb.size() == 0 && !wbm_cyc_o && (npix < 96 || done_cnt > 0)) fin = 1'b1;
      if (cycles > 3000) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: idx %0d pending %0d, required load to complete", idx, sb.size());
        fin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pix_ready, busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 7'd0 || word_cnt !== 6'd0 ||
        wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready %b busy %b done %b err %b cyc %b adr %h dat %h wc %0d, required all 0",
               pix_ready, busy, done, err, wbm_cyc_o, wbm_adr_o, wbm_dat_o, word_cnt);
    end
  endtask

  task automatic test_single();
    int dc, ctd;
    bit ab;
    do_reset();
    run_load(2'd0, 3, 1, 1, 0, 1'b0, -1, -1, dc, ctd, ab);
    @(negedge clk); #1;
    checks++;
    if (last_adr !== 32'h3000_0100 || last_dat !== 32'h0003_0201 || writes != 1) begin
      errors++;
      $display("FAIL single_word: adr %h dat %h writes %0d, required 30000100 00030201 1", last_adr, last_dat, writes);
    end
    checks++;
    if (word_cnt !== 6'd1) begin
      errors++;
      $display("FAIL single_word_cnt: %0d, required 1", word_cnt);
    end
    checks++;
    if (pix_ready !== 1'b1 || last_low_run != 2) begin
      errors++;
      $display("FAIL ready_gap: ready %b low cycles %0d, required ready 1 after 2 low", pix_ready, last_low_run);
    end
  endtask

  task automatic test_full();
    int dc, ctd;
    bit ab;
    do_reset();
    run_load(2'd2, 96, 1, 0, 0, 1'b0, -1, -1, dc, ctd, ab);
    repeat (4) begin
      @(negedge clk); #1;
      if (done) dc++;
    end
    checks++;
    if (writes != 32 || last_adr !== 32'h3200_017C || last_dat !== 32'h005F_5E5D) begin
      errors++;
      $display("FAIL full_load: writes %0d last adr %h dat %h, required 32 3200017c 005f5e5d", writes, last_adr, last_dat);
    end
    checks++;
    if (dc != 1) begin
      errors++;
      $display("FAIL done_once: %0d pulses, required 1", dc);
    end
    checks++;
    if (ctd < 160) begin
      errors++;
      $display("FAIL full_latency: %0d cycles, required at least 160", ctd);
    end
    checks++;
    if (word_cnt !== 6'd32 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL after_full: wc %0d busy %b ready %b, required 32 0 0", word_cnt, busy, pix_ready);
    end
  endtask

  task automatic test_wait_random();
    int dc, ctd;
    bit ab;
    do_reset();
    run_load(2'd1, 96, 7, 3, 3, 1'b1, -1, -1, dc, ctd, ab);
    checks++;
    if (writes != 32 || dc != 1 || last_adr !== 32'h3100_017C) begin
      errors++;
      $display("FAIL wait_random: writes %0d done %0d last adr %h, required 32 1 3100017c", writes, dc, last_adr);
    end
  endtask

  task automatic test_start_busy_and_bad_inst();
    int dc, ctd;
    bit ab;
    bit saw_cyc = 1'b0;
    int w0;
    do_reset();
    run_load(2'd0, 96, 3, 5, 0, 1'b0, 50, -1, dc, ctd, ab);
    checks++;
    if (writes != 32 || dc != 1 || last_adr !== 32'h3000_017C || word_cnt !== 6'd32) begin
      errors++;
      $display("FAIL start_busy: writes %0d done %0d last adr %h wc %0d, required 32 1 3000017c 32", writes, dc, last_adr, word_cnt);
    end
    w0 = writes;
    @(negedge clk); #1;
    start = 1'b1;
    inst_sel = 2'd3;
    @(negedge clk); #1;
    start = 1'b0;
    inst_sel = 2'd0;
    repeat (10) begin
      @(negedge clk); #1;
      if (wbm_cyc_o) saw_cyc = 1'b1;
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || saw_cyc || writes != w0) begin
      errors++;
      $display("FAIL bad_inst: err %b busy %b cyc_seen %b writes %0d, required 1 0 0 %0d", err, busy, saw_cyc, writes, w0);
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || word_cnt !== 6'd0) begin
      errors++;
      $display("FAIL err_clear: err %b busy %b wc %0d, required 0 1 0", err, busy, word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int dc, ctd;
    bit ab;
    do_reset();
    run_load(2'd1, 96, 1, 9, 3, 1'b0, -1, 10, dc, ctd, ab);
    checks++;
    if (!ab) begin
      errors++;
      $display("FAIL abort_reached: %b, required 1", ab);
    end
    wb_rst_i  = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0 || word_cnt !== 6'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cyc %b stb %b busy %b wc %0d done %b, required 0 0 0 0 0",
               wbm_cyc_o, wbm_stb_o, busy, word_cnt, done);
    end
    wb_rst_i = 1'b0;
    sb.delete();
    run_load(2'd0, 3, 1, 1, 0, 1'b0, -1, -1, dc, ctd, ab);
    checks++;
    if (writes != 1 || last_adr !== 32'h3000_0100 || last_dat !== 32'h0003_0201 || word_cnt !== 6'd1) begin
      errors++;
      $display("FAIL restart: writes %0d adr %h dat %h wc %0d, required 1 30000100 00030201 1", writes, last_adr, last_dat, word_cnt);
    end
  endtask

  task automatic test_no_ack();
    int stb_cycles = 0;
    bit saw_done = 1'b0;
    do_reset();
    ack_en = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    inst_sel = 2'd0;
    pix_valid = 1'b1;
    pix_data = 8'h11;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (200) begin
      @(negedge clk); #1;
      if (wbm_stb_o) stb_cycles++;
      if (done) saw_done = 1'b1;
    end
`ifdef WB_TIMEOUT_EN
    checks++;
    if (stb_cycles != 64 || err !== 1'b1 || busy !== 1'b0 || saw_done || word_cnt !== 6'd0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout: stb %0d err %b busy %b done %b wc %0d, required 64 1 0 0 0", stb_cycles, err, busy, saw_done, word_cnt);
    end
`else
    checks++;
    if (wbm_stb_o !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || saw_done || stb_cycles < 150) begin
      errors++;
      $display("FAIL wait_forever: stb %b cycles %0d err %b busy %b, required stb held, err 0 busy 1", wbm_stb_o, stb_cycles, err, busy);
    end
`endif
    pix_valid = 1'b0;
    ack_en = 1'b1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_wait_random();
    test_start_busy_and_bad_inst();
    test_reset_mid();
    test_no_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
